// File: rtl/nec_ir_tx_seq_if.sv
// Sequencer-side bundle: show-ahead TX FIFO head/pop plus envelope and status outputs.
// master = frame sequencer, slave = FIFO/modulator/register side.
interface nec_ir_tx_seq_if;
  logic        fifo_tx_empty;
  logic [15:0] fifo_tx_rdata;
  logic        fifo_tx_read;
  logic        ir_tx;
  logic        tx_busy;
  logic        tx_frame_done;
  logic        tx_repeat;

  modport master (
    input  fifo_tx_empty, fifo_tx_rdata,
    output fifo_tx_read, ir_tx, tx_busy, tx_frame_done, tx_repeat
  );

  modport slave (
    output fifo_tx_empty, fifo_tx_rdata,
    input  fifo_tx_read, ir_tx, tx_busy, tx_frame_done, tx_repeat
  );
endinterface

// File: rtl/nec_ir_tx_seq.sv
// NEC IR frame sequencer: pops {addr,cmd} at frame slots and drives the leader/bit/stop envelope in ticks.
// Pop is combinational with the starting tick; a new word waits for IDLE or the next FRAME_TICKS boundary.
module nec_ir_tx_seq #(
  parameter int TWIDTH      = 8,
  parameter int FRAME_TICKS = 192,
  parameter int LEAD_MARK   = 16,
  parameter int LEAD_SPACE  = 8,
  parameter int RPT_SPACE   = 4
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           tick,
  input  logic           cfg_ir_en,
  input  logic           cfg_ir_tx_en,
  input  logic           cfg_repeat_en,
  input  logic           cfg_tx_polarity,
  nec_ir_tx_seq_if.master bus
);

  typedef enum logic [2:0] {IDLE, LEAD_M, LEAD_S, BIT_M, BIT_S, STOP_M, GAP} state_t;

  state_t            state_q, state_d;
  logic [TWIDTH-1:0] seg_q, seg_d;
  logic [TWIDTH-1:0] period_q, period_d;
  logic [4:0]        idx_q, idx_d;
  logic [31:0]       shift_q, shift_d;
  logic              last_q, last_d;
  logic              rpt_q, rpt_d;
  logic              read_c, done_c, start_data, start_rpt;
  logic              en, seg_end, mark;
  logic [7:0]        hd_addr, hd_data;

  assign en      = cfg_ir_en & cfg_ir_tx_en;
  assign seg_end = tick && (seg_q == TWIDTH'(1));
  assign hd_addr = bus.fifo_tx_rdata[15:8];
  assign hd_data = bus.fifo_tx_rdata[7:0];

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      seg_q    <= '0;
      period_q <= '0;
      idx_q    <= '0;
      shift_q  <= '0;
      last_q   <= 1'b0;
      rpt_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      seg_q    <= seg_d;
      period_q <= period_d;
      idx_q    <= idx_d;
      shift_q  <= shift_d;
      last_q   <= last_d;
      rpt_q    <= rpt_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    seg_d      = seg_q;
    period_d   = period_q;
    idx_d      = idx_q;
    shift_d    = shift_q;
    last_d     = last_q;
    rpt_d      = rpt_q;
    read_c     = 1'b0;
    done_c     = 1'b0;
    start_data = 1'b0;
    start_rpt  = 1'b0;

    if (!en) begin
      // Disabling abandons any partial frame; it is never resumed.
      state_d = IDLE;
      last_d  = 1'b0;
      rpt_d   = 1'b0;
    end else begin
      if (tick && state_q != IDLE) begin
        if (period_q != TWIDTH'(FRAME_TICKS)) period_d = period_q + TWIDTH'(1);
        if (seg_q != '0) seg_d = seg_q - TWIDTH'(1);
      end

      case (state_q)
        IDLE: begin
          if (tick && !bus.fifo_tx_empty) start_data = 1'b1;
        end
        LEAD_M: begin
          if (seg_end) begin
            state_d = LEAD_S;
            seg_d   = rpt_q ? TWIDTH'(RPT_SPACE) : TWIDTH'(LEAD_SPACE);
          end
        end
        LEAD_S: begin
          if (seg_end) begin
            state_d = rpt_q ? STOP_M : BIT_M;
            seg_d   = TWIDTH'(1);
            idx_d   = '0;
          end
        end
        BIT_M: begin
          if (seg_end) begin
            state_d = BIT_S;
            seg_d   = shift_q[0] ? TWIDTH'(3) : TWIDTH'(1);
          end
        end
        BIT_S: begin
          if (seg_end) begin
            shift_d = {1'b0, shift_q[31:1]};
            seg_d   = TWIDTH'(1);
            if (idx_q == 5'd31) begin
              state_d = STOP_M;
            end else begin
              idx_d   = idx_q + 5'd1;
              state_d = BIT_M;
            end
          end
        end
        STOP_M: begin
          if (seg_end) begin
            state_d = GAP;
            done_c  = 1'b1;
            last_d  = 1'b1;
          end
        end
        GAP: begin
          // The tick that completes the frame period is also the next frame's start.
          if (tick && period_q >= TWIDTH'(FRAME_TICKS - 1)) begin
            if (!bus.fifo_tx_empty) begin
              start_data = 1'b1;
            end else if (cfg_repeat_en && last_q) begin
              start_rpt = 1'b1;
            end else begin
              state_d = IDLE;
              last_d  = 1'b0;
            end
          end
        end
        default: state_d = IDLE;
      endcase

      if (start_data) begin
        read_c   = 1'b1;
        shift_d  = {~hd_data, hd_data, ~hd_addr, hd_addr};
        seg_d    = TWIDTH'(LEAD_MARK);
        period_d = '0;
        rpt_d    = 1'b0;
        state_d  = LEAD_M;
      end else if (start_rpt) begin
        seg_d    = TWIDTH'(LEAD_MARK);
        period_d = '0;
        rpt_d    = 1'b1;
        state_d  = LEAD_M;
      end
    end
  end

  assign mark              = (state_q == LEAD_M) || (state_q == BIT_M) || (state_q == STOP_M);
  assign bus.ir_tx         = mark ? ~cfg_tx_polarity : cfg_tx_polarity;
  assign bus.fifo_tx_read  = read_c & rst_n;
  assign bus.tx_frame_done = done_c & rst_n;
  assign bus.tx_busy       = (state_q != IDLE);
  assign bus.tx_repeat     = rpt_q;

endmodule
